// File: rtl/button_gesture_pkg.sv
// ============================================================
// button_gesture_pkg : shared constants for the handlebar button path
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

package button_gesture_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'b00;
  localparam state_t ST_HOLD      = 2'b01;
  localparam state_t ST_GAP       = 2'b10;
  localparam state_t ST_LONG_WAIT = 2'b11;

  // Defaults assume a 100 MHz clock
  localparam int CNT_W_DEF        = 27;
  localparam int WIN_CNT_DEF      = 30_000_000;   // 300 ms click window
  localparam int LONG_CNT_DEF     = 100_000_000;  // 1 s long-press hold
  localparam int DEBOUNCE_CNT_DEF = 1_000_000;    // 10 ms debouncer settle

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SINGLE = 2'd1,
    EVT_DOUBLE = 2'd2,
    EVT_LONG   = 2'd3
  } evt_kind_t;

  // Tap count saturates at two: anything beyond a double is still a double
  function automatic logic [1:0] taps_inc(input logic [1:0] taps);
    return (taps >= 2'd2) ? 2'd2 : taps + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================
// sync_2ff : two-flop synchroniser for raw asynchronous inputs
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_gesture.sv
// ============================================================
// button_gesture : classifies debounced presses as single, double or long
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN_CNT  = WIN_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic press_tick,
  input  logic btn_n,
  output logic evt_single,
  output logic evt_double,
  output logic evt_long,
  output logic busy
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

  logic             btn_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [1:0]       taps;
  logic [1:0]       taps_nxt;
  evt_kind_t        evt_nxt;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_s)
  );

  // One event code per cycle keeps the three pulses mutually exclusive
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    taps_nxt  = taps;
    evt_nxt   = EVT_NONE;
    case (state)
      ST_IDLE: begin
        if (press_tick) begin
          taps_nxt  = 2'd1;
          timer_nxt = '0;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (btn_s) begin
          timer_nxt = '0;
          state_nxt = ST_GAP;
        end else if (taps == 2'd1 && timer == LONG_LAST) begin
          evt_nxt   = EVT_LONG;
          state_nxt = ST_LONG_WAIT;
        end else if (timer != LONG_LAST) begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      ST_GAP: begin
        // A tick on the timeout cycle extends the gesture rather than ending it
        if (press_tick) begin
          taps_nxt  = taps_inc(taps);
          timer_nxt = '0;
          state_nxt = ST_HOLD;
        end else if (timer == WIN_LAST) begin
          evt_nxt   = (taps == 2'd1) ? EVT_SINGLE : EVT_DOUBLE;
          taps_nxt  = '0;
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      ST_LONG_WAIT: begin
        if (btn_s) begin
          taps_nxt  = '0;
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      taps       <= '0;
      evt_single <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      taps       <= taps_nxt;
      evt_single <= (evt_nxt == EVT_SINGLE);
      evt_double <= (evt_nxt == EVT_DOUBLE);
      evt_long   <= (evt_nxt == EVT_LONG);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire
